// File: rtl/piso_serializer.sv
// piso_serializer: LSB-first parallel-to-serial converter, valid/ready load.
// Define PISO_SERIALIZER_PARITY_EN to append an even-parity bit per frame.
module piso_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_ready,
  output logic             o_sd,
  output logic             o_sd_valid,
  output logic             o_done
);

`ifdef PISO_SERIALIZER_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam int CW = $clog2(FRAME);
  localparam logic [CW-1:0] CNT_LOAD = CW'(FRAME - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [FRAME-1:0] sh;
  logic [FRAME-1:0] sh_n;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_n;
  logic             done_n;
  logic [FRAME-1:0] frame;
  logic             last;
  logic             accept;

`ifdef PISO_SERIALIZER_PARITY_EN
  assign frame = {^i_data, i_data};
`else
  assign frame = i_data;
`endif

  // last bit is consumed on this edge; a new word may load in its place
  assign last    = (state == SHIFT) && (cnt == '0) && i_en;
  assign o_ready = (state == IDLE) || last;
  assign accept  = i_valid && o_ready;

  assign o_sd       = (state == SHIFT) && sh[0];
  assign o_sd_valid = (state == SHIFT);

  // state, shift register, counter and done pulse registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state  <= IDLE;
      sh     <= '0;
      cnt    <= '0;
      o_done <= 1'b0;
    end else begin
      state  <= state_n;
      sh     <= sh_n;
      cnt    <= cnt_n;
      o_done <= done_n;
    end
  end

  // next-state: load on accept, shift on enable, reload or retire at last bit
  always_comb begin
    state_n = state;
    sh_n    = sh;
    cnt_n   = cnt;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_n = SHIFT;
          sh_n    = frame;
          cnt_n   = CNT_LOAD;
        end
      end
      SHIFT: begin
        if (i_en) begin
          if (cnt == '0) begin
            done_n = 1'b1;
            if (accept) begin
              sh_n  = frame;
              cnt_n = CNT_LOAD;
            end else begin
              state_n = IDLE;
              sh_n    = '0;
            end
          end else begin
            sh_n  = sh >> 1;
            cnt_n = cnt - CW'(1);
          end
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in, serial-out serializer with a valid/ready load handshake and a per-bit shift enable. A WIDTH-bit word accepted on the parallel side is driven out one bit per enabled clock, LSB first, with a serial-valid qualifier. The serial side sits on a chain of enable-gated flip-flop stages; the same enable strobe (i_en) paces both ends. Back-to-back words stream with no gap.

## Interface
- WIDTH, 8, parallel word width in bits; legal range 2..32.
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst_n  input  1  asynchronous active-low reset; clears all state immediately.
- i_en  input  1  shift strobe; the current serial bit is consumed on an edge where i_en=1.
- i_valid  input  1  parallel word offered.
- i_data  input  WIDTH  parallel word; sampled only when the word is accepted.
- o_ready  output  1  block can accept a word this cycle.
- o_sd  output  1  current serial bit.
- o_sd_valid  output  1  o_sd carries a valid bit.
- o_done  output  1  one-cycle pulse after the last bit of a word is consumed.

## Operation
- The FSM has two states: IDLE and SHIFT. A shift register sh[FRAME-1:0] and a bit counter cnt, ceil(log2(FRAME)) bits wide, hold the word in flight. FRAME=WIDTH, or WIDTH+1 with parity (see Configuration).
- Reset values: state=IDLE, sh=0, cnt=0, o_sd=0, o_sd_valid=0, o_done=0. o_ready=1 after reset is released.
- Accept: the word is accepted on an edge where i_valid=1 and o_ready=1. On that edge sh<=frame, cnt<=FRAME-1, and state<=SHIFT.
- o_ready is combinational: (state==IDLE) | (state==SHIFT & cnt==0 & i_en).
- In SHIFT: o_sd=sh[0] and o_sd_valid=1.
  - On an edge with i_en=1: sh shifts right by one (0 fills the MSB) and cnt decrements.
  - On an edge with i_en=0: all state holds.
- Last bit (cnt==0 and i_en=1):
  - If a word is accepted on the same edge, it is loaded and state stays SHIFT.
  - Otherwise state<=IDLE and sh<=0.
  - In both cases o_done<=1 for exactly one cycle.
- In IDLE: o_sd=0, o_sd_valid=0, and i_en is ignored.
- While o_ready=0, i_valid and i_data are ignored. The source holds the word until it is accepted; this block does not buffer it.
- Reset mid-word: the partial word is dropped, o_done is not pulsed, and outputs go to their reset values asynchronously.

## Timing
- Load latency: bit 0 is on o_sd in the cycle immediately after the accept edge.
- With i_en tied to 1, one word occupies exactly FRAME cycles of o_sd_valid=1.
- Back-to-back words: o_sd_valid stays high continuously and the next bit 0 follows the previous last bit with no bubble.
- o_done is high in the cycle after the edge that consumed the last bit, i.e. coincident with the next word's bit 0 when streaming.
- Worst-case combinational path: i_en -> o_ready. The source must not make i_valid depend combinationally on o_ready.

## Configuration
- PISO_SERIALIZER_PARITY_EN defined:
  - FRAME=WIDTH+1.
  - An even-parity bit (^i_data), computed at accept, is appended as the final serial bit.
- PISO_SERIALIZER_PARITY_EN undefined:
  - FRAME=WIDTH.
  - No parity logic is built; cnt is sized for WIDTH.

## Test plan
- Reset and idle: hold i_rst_n=0, then release, with i_valid=0 and i_en=1 for 10 cycles -> o_ready=1, o_sd_valid=0, o_sd=0, o_done=0 throughout.
- Single word: WIDTH=8, load 0xA5 with i_en=1 -> o_sd sequence 1,0,1,0,0,1,0,1 over 8 valid cycles, then o_done pulses once and state returns to IDLE. With parity enabled, a 9th bit 0 is sent.
- Gated enable: load 0x3C, then toggle i_en 1,0,1,0... -> each bit holds for 2 cycles; bits 0,0,1,1,1,1,0,0; o_done after 16 cycles.
- Back-to-back: offer 0xFF then 0x00, with i_valid held and i_en=1 -> 16 contiguous valid cycles (8 ones, then 8 zeros); o_ready=1 only on the accept cycles; o_done pulses at cycle 8 and cycle 16.
- Busy ignore: offer 0x12, then change i_data to 0x34 with i_valid=1 during the shift -> the serial output is 0x12 and 0x34 is accepted only at the last-bit cycle.
- Reset mid-word: drop i_rst_n during bit 4 of 0x5A -> o_sd_valid falls immediately, no o_done, and a fresh load after release serializes correctly.
